// File: rtl/ysyx_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_bus_pkg : state/owner encodings shared by bus masters        |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_R_ADDR = 3'd1,
    ST_R_DATA = 3'd2,
    ST_W_ADDR = 3'd3,
    ST_W_RESP = 3'd4
  } bus_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } bus_owner_e;

  localparam int unsigned TMO_W_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/ysyx_bus_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_bus_timeout : clearable saturating counter, expire at max    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module ysyx_bus_timeout
  import ysyx_bus_pkg::*;
#(
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TMO_W-1:0] cnt_q;

  assign expire_o = &cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_bus_arbiter : IFU/LSU arbiter onto one memory bus port       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module ysyx_bus_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TMO_W  = TMO_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr_i,
  input  logic                ifu_arvalid_i,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_rvalid_o,
  output logic                ifu_err_o,
  input  logic [ADDR_W-1:0]   lsu_araddr_i,
  input  logic                lsu_arvalid_i,
  input  logic [ADDR_W-1:0]   lsu_awaddr_i,
  input  logic                lsu_awvalid_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_rvalid_o,
  output logic                lsu_bvalid_o,
  output logic                lsu_err_o,
  output logic [ADDR_W-1:0]   mem_araddr_o,
  output logic                mem_arvalid_o,
  input  logic                mem_arready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic [ADDR_W-1:0]   mem_awaddr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic                mem_awvalid_o,
  input  logic                mem_awready_i,
  input  logic                mem_bvalid_i,
  output logic                busy_o
);

  bus_state_e          state_q;
  bus_owner_e          owner_q, last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic                w_expire;
  logic                w_grant, w_gnt_write;
  bus_owner_e          w_gnt_owner;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic                w_rd_done, w_rd_tmo, w_rd_rsp, w_wr_done, w_wr_tmo;
  logic [DATA_W-1:0]   w_rdata;

  ysyx_bus_timeout #(.TMO_W(TMO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_IDLE),
    .en_i     (state_q != ST_IDLE),
    .expire_o (w_expire)
  );

  // On an IFU/LSU tie the master that did not own the bus last time wins.
  always_comb begin
    w_grant     = 1'b0;
    w_gnt_write = 1'b0;
    w_gnt_owner = OWN_IFU;
    w_gnt_addr  = ifu_araddr_i;
    if ((lsu_awvalid_i || lsu_arvalid_i) && (!ifu_arvalid_i || last_q == OWN_IFU)) begin
      w_grant     = 1'b1;
      w_gnt_owner = OWN_LSU;
      w_gnt_write = lsu_awvalid_i;
      w_gnt_addr  = lsu_awvalid_i ? lsu_awaddr_i : lsu_araddr_i;
    end else if (ifu_arvalid_i) begin
      w_grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (w_grant) begin
          owner_q <= w_gnt_owner;
          last_q  <= w_gnt_owner;
          addr_q  <= w_gnt_addr;
          if (w_gnt_write) begin
            wdata_q <= lsu_wdata_i;
            wstrb_q <= lsu_wstrb_i;
            state_q <= ST_W_ADDR;
          end else begin
            state_q <= ST_R_ADDR;
          end
        end
        ST_R_ADDR: if (w_expire) state_q <= ST_IDLE;
                   else if (mem_arready_i) state_q <= ST_R_DATA;
        ST_R_DATA: if (mem_rvalid_i || w_expire) state_q <= ST_IDLE;
        ST_W_ADDR: if (w_expire) state_q <= ST_IDLE;
                   else if (mem_awready_i) state_q <= ST_W_RESP;
        ST_W_RESP: if (mem_bvalid_i || w_expire) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // A genuine response in the expiry cycle takes precedence over the timeout.
  assign w_rd_done = (state_q == ST_R_DATA) && mem_rvalid_i;
  assign w_rd_tmo  = (state_q == ST_R_ADDR || state_q == ST_R_DATA) && w_expire && !w_rd_done;
  assign w_rd_rsp  = w_rd_done || w_rd_tmo;
  assign w_rdata   = w_rd_done ? mem_rdata_i : '0;
  assign w_wr_done = (state_q == ST_W_RESP) && mem_bvalid_i;
  assign w_wr_tmo  = (state_q == ST_W_ADDR || state_q == ST_W_RESP) && w_expire && !w_wr_done;

  assign ifu_rvalid_o = w_rd_rsp && (owner_q == OWN_IFU);
  assign ifu_rdata_o  = ifu_rvalid_o ? w_rdata : '0;
  assign ifu_err_o    = ifu_rvalid_o && w_rd_tmo;

  assign lsu_rvalid_o = w_rd_rsp && (owner_q == OWN_LSU);
  assign lsu_rdata_o  = lsu_rvalid_o ? w_rdata : '0;
  assign lsu_bvalid_o = w_wr_done || w_wr_tmo;
  assign lsu_err_o    = (lsu_rvalid_o && w_rd_tmo) || w_wr_tmo;

  assign mem_araddr_o  = addr_q;
  assign mem_arvalid_o = (state_q == ST_R_ADDR) && !w_expire;
  assign mem_awaddr_o  = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wstrb_o   = wstrb_q;
  assign mem_awvalid_o = (state_q == ST_W_ADDR) && !w_expire;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ysyx_bus_arbiter : directed self-checking bench                |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_ysyx_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] ifu_araddr_i = '0;
  logic              ifu_arvalid_i = 1'b0;
  logic [DATA_W-1:0] ifu_rdata_o;
  logic              ifu_rvalid_o, ifu_err_o;
  logic [ADDR_W-1:0] lsu_araddr_i = '0, lsu_awaddr_i = '0;
  logic              lsu_arvalid_i = 1'b0, lsu_awvalid_i = 1'b0;
  logic [DATA_W-1:0] lsu_wdata_i = '0;
  logic [3:0]        lsu_wstrb_i = '0;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_rvalid_o, lsu_bvalid_o, lsu_err_o;
  logic [ADDR_W-1:0] mem_araddr_o, mem_awaddr_o;
  logic              mem_arvalid_o, mem_awvalid_o;
  logic              mem_arready_i = 1'b0, mem_awready_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_rvalid_i = 1'b0, mem_bvalid_i = 1'b0;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  logic              busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr_i(ifu_araddr_i), .ifu_arvalid_i(ifu_arvalid_i),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_err_o(ifu_err_o),
    .lsu_araddr_i(lsu_araddr_i), .lsu_arvalid_i(lsu_arvalid_i),
    .lsu_awaddr_i(lsu_awaddr_i), .lsu_awvalid_i(lsu_awvalid_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_bvalid_o(lsu_bvalid_o), .lsu_err_o(lsu_err_o),
    .mem_araddr_o(mem_araddr_o), .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_awaddr_o(mem_awaddr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i),
    .mem_bvalid_i(mem_bvalid_i), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Serves one read that was granted in the previous cycle; releases the owner's request.
  task automatic serve_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic to_ifu);
    step(); #1;
    chk({tag, ".arvalid"}, mem_arvalid_o, 1'b1);
    chk({tag, ".araddr"}, mem_araddr_o, addr);
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = data;
    #1;
    chk({tag, ".ifu_rvalid"}, ifu_rvalid_o, to_ifu);
    chk({tag, ".lsu_rvalid"}, lsu_rvalid_o, !to_ifu);
    chk({tag, ".rdata"}, to_ifu ? ifu_rdata_o : lsu_rdata_o, data);
    chk({tag, ".err"}, ifu_err_o | lsu_err_o, 1'b0);
    if (to_ifu) ifu_arvalid_i = 1'b0;
    else        lsu_arvalid_i = 1'b0;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #1;
    chk({tag, ".idle_after"}, busy_o, 1'b0);
  endtask

  initial begin
    int hi_cnt;

    // Reset state
    #2;
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.valids", {ifu_rvalid_o, ifu_err_o, lsu_rvalid_o, lsu_bvalid_o, lsu_err_o,
                       mem_arvalid_o, mem_awvalid_o}, 7'b0);
    chk("rst.data", {mem_araddr_o, mem_wdata_o}, 64'h0);
    step(); rst = 1'b1;

    // Basic IFU read, minimum latency
    step();
    ifu_araddr_i = 32'h8000_0000; ifu_arvalid_i = 1'b1;
    #1 chk("rd1.busyN", busy_o, 1'b0);
    serve_read("rd1", 32'h8000_0000, 32'hDEAD_BEEF, 1'b1);

    // Tie after reset: LSU first, then IFU wins the next tie
    ifu_araddr_i = 32'h8000_0004; ifu_arvalid_i = 1'b1;
    lsu_araddr_i = 32'h8000_0200; lsu_arvalid_i = 1'b1;
    serve_read("tie1", 32'h8000_0200, 32'h1111_1111, 1'b0);
    lsu_araddr_i = 32'h8000_0300; lsu_arvalid_i = 1'b1;
    serve_read("tie2", 32'h8000_0004, 32'h2222_2222, 1'b1);
    serve_read("tie3", 32'h8000_0300, 32'h3333_3333, 1'b0);

    // LSU write beats LSU read
    lsu_awaddr_i = 32'h8000_0100; lsu_wdata_i = 32'h1234_5678; lsu_wstrb_i = 4'hF;
    lsu_awvalid_i = 1'b1;
    lsu_araddr_i = 32'h8000_0400; lsu_arvalid_i = 1'b1;
    step(); #1;
    chk("wr.awvalid", mem_awvalid_o, 1'b1);
    chk("wr.arvalid", mem_arvalid_o, 1'b0);
    chk("wr.awaddr", mem_awaddr_o, 32'h8000_0100);
    chk("wr.wdata", mem_wdata_o, 32'h1234_5678);
    chk("wr.wstrb", mem_wstrb_o, 4'hF);
    mem_awready_i = 1'b1;
    lsu_awvalid_i = 1'b0;
    step();
    mem_awready_i = 1'b0;
    #1 chk("wr.bvalid_early", lsu_bvalid_o, 1'b0);
    mem_bvalid_i = 1'b1;
    #1;
    chk("wr.bvalid", lsu_bvalid_o, 1'b1);
    chk("wr.err", lsu_err_o, 1'b0);
    chk("wr.rvalids", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
    step();
    mem_bvalid_i = 1'b0;
    #1 chk("wr.idle", {busy_o, lsu_bvalid_o}, 2'b00);
    serve_read("wr_rd", 32'h8000_0400, 32'hCAFE_F00D, 1'b0);

    // Address-phase timeout: arvalid for 255 cycles, then error response
    ifu_araddr_i = 32'h8000_0008; ifu_arvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    hi_cnt = 0;
    for (int k = 1; k <= 255; k++) begin
      step(); #1;
      if (mem_arvalid_o && !ifu_rvalid_o) hi_cnt++;
    end
    chk("tmo.wait_cycles", hi_cnt, 255);
    step(); #1;
    chk("tmo.rvalid", ifu_rvalid_o, 1'b1);
    chk("tmo.err", ifu_err_o, 1'b1);
    chk("tmo.rdata", ifu_rdata_o, 32'h0);
    chk("tmo.arvalid", mem_arvalid_o, 1'b0);
    chk("tmo.lsu", lsu_rvalid_o, 1'b0);
    ifu_arvalid_i = 1'b0;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    #1 chk("tmo.stray", {ifu_rvalid_o, lsu_rvalid_o, busy_o}, 3'b000);
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Data-phase: real response in the expiry cycle wins
    ifu_araddr_i = 32'h8000_000C; ifu_arvalid_i = 1'b1;
    step(); #1;
    chk("tie_tmo.arvalid", mem_arvalid_o, 1'b1);
    mem_arready_i = 1'b1;
    for (int k = 2; k <= 255; k++) begin
      step();
      mem_arready_i = 1'b0;
    end
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_0001;
    #1;
    chk("tie_tmo.rvalid", ifu_rvalid_o, 1'b1);
    chk("tie_tmo.err", ifu_err_o, 1'b0);
    chk("tie_tmo.rdata", ifu_rdata_o, 32'hA5A5_0001);
    ifu_arvalid_i = 1'b0;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Async reset during R_DATA
    ifu_araddr_i = 32'h8000_0010; ifu_arvalid_i = 1'b1;
    step(); mem_arready_i = 1'b1;
    step(); mem_arready_i = 1'b0;
    #1 chk("arst.busy_before", busy_o, 1'b1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    #1 rst = 1'b0;
    #1;
    chk("arst.busy", busy_o, 1'b0);
    chk("arst.outs", {ifu_rvalid_o, ifu_err_o, lsu_rvalid_o, mem_arvalid_o}, 4'b0000);
    chk("arst.rdata", ifu_rdata_o, 32'h0);
    chk("arst.araddr", mem_araddr_o, 32'h0);
    ifu_arvalid_i = 1'b0;
    step();
    rst = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    ifu_araddr_i = 32'h8000_0014; ifu_arvalid_i = 1'b1;
    serve_read("arst.rd", 32'h8000_0014, 32'h0BAD_CAFE, 1'b1);

    // Spurious responses in IDLE
    mem_rvalid_i = 1'b1; mem_bvalid_i = 1'b1; mem_rdata_i = 32'h9999_9999;
    #1 chk("spur.outs", {ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o, ifu_err_o, lsu_err_o}, 5'b0);
    step();
    mem_rvalid_i = 1'b0; mem_bvalid_i = 1'b0;
    #1 chk("spur.busy", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
